// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: BCD digit definitions shared by the scan counter and the 7-segment decoder
package bcd_disp_pkg;
   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
   typedef logic [DIGIT_W-1:0] bcd_digit_t;
endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one BCD decade with carry/borrow out for chaining
module bcd_digit_cell
   import bcd_disp_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       load,
   input  bcd_digit_t load_digit,
   input  logic       step_in,
   input  logic       up,
   output bcd_digit_t digit,
   output logic       step_out
);
   assign step_out = step_in & (up ? digit == BCD_MAX : digit == '0);
   always_ff @(posedge clk) begin
      if (!rst_n || clear)
         digit <= '0;
      else if (load)
         digit <= load_digit > BCD_MAX ? '0 : load_digit;
      else if (step_in)
         digit <= up ? (digit == BCD_MAX ? '0 : digit + 1'b1) : (digit == '0 ? BCD_MAX : digit - 1'b1);
   end
endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: BCD up/down counter with multiplexed digit scan output.
// Define BCD_SCAN_LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module bcd_scan_counter
   import bcd_disp_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  en,
   input  logic                  up,
   output logic [4*DIGITS-1:0]   count,
   output logic                  wrap,
   output logic [3:0]            bcd,
   output logic [DIGITS-1:0]     dig_sel
);
   localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   logic [PW-1:0] pre;
   logic [SW-1:0] idx;
   logic [DIGITS:0] c;
   logic tc;
   logic [DIGITS-1:0] onehot;
   bcd_digit_t d [DIGITS];
   assign c[0] = en;
   for (genvar i = 0; i < DIGITS; i++) begin : g_cell
      bcd_digit_cell u_cell (
         .clk        (clk),
         .rst_n      (rst_n),
         .clear      (clear),
         .load       (load),
         .load_digit (load_val[4*i +: 4]),
         .step_in    (c[i]),
         .up         (up),
         .digit      (d[i]),
         .step_out   (c[i+1])
      );
      assign count[4*i +: 4] = d[i];
   end
   assign tc = pre == PW'(SCAN_DIV - 1);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre  <= '0;
         idx  <= '0;
         wrap <= 1'b0;
      end else begin
         pre  <= tc ? '0 : pre + 1'b1;
         if (tc)
            idx <= idx == SW'(DIGITS - 1) ? '0 : idx + 1'b1;
         wrap <= c[DIGITS] & ~clear & ~load;
      end
   end
   assign bcd    = d[idx];
   assign onehot = DIGITS'(1) << idx;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] lz;
   // lz[i]: digit i and every digit above it are zero
   always_comb begin
      lz = '0;
      lz[DIGITS-1] = d[DIGITS-1] == '0;
      for (int i = DIGITS - 2; i >= 0; i--) lz[i] = lz[i+1] & (d[i] == '0);
   end
   assign dig_sel = (idx != '0 && lz[idx]) ? '0 : onehot;
`else
   assign dig_sel = onehot;
`endif
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: randomized check of bcd_scan_counter against a decimal reference model
module tb_bcd_scan_counter;
   logic clk = 0, rst_n, clear, load, en, up;
   logic [15:0] load_val, count;
   logic wrap;
   logic [3:0] bcd;
   logic [3:0] dig_sel;
   int n = 0, errs = 0;
   int val = 0, k = 0;
   logic wexp = 0;

   bcd_scan_counter #(.DIGITS(4), .SCAN_DIV(3)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
      .en(en), .up(up), .count(count), .wrap(wrap), .bcd(bcd), .dig_sel(dig_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int from_load(input logic [15:0] lv);
      int s = 0, p = 1;
      for (int i = 0; i < 4; i++) begin
         s += (lv[4*i +: 4] > 9 ? 0 : int'(lv[4*i +: 4])) * p;
         p *= 10;
      end
      return s;
   endfunction

   task automatic cyc(input logic r, input logic c, input logic l, input logic e, input logic u,
                      input logic [15:0] lv);
      int di, p;
      logic [3:0] sel;
      rst_n = r; clear = c; load = l; en = e; up = u; load_val = lv;
      @(posedge clk);
      wexp = 0;
      if (!r) begin
         val = 0; k = 0;
      end else begin
         k++;
         if (c) val = 0;
         else if (l) val = from_load(lv);
         else if (e && u) begin wexp = val == 9999; val = (val + 1) % 10000; end
         else if (e) begin wexp = val == 0; val = (val + 9999) % 10000; end
      end
      #1;
      di = (k / 3) % 4;
      p = 1;
      for (int i = 0; i < di; i++) p *= 10;
      sel = 4'(1 << di);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
      if (di > 0 && val < p) sel = '0;
`endif
      chk("count", 32'(count), 32'(to_bcd(val)));
      chk("wrap", 32'(wrap), 32'(wexp));
      chk("bcd", 32'(bcd), 32'((val / p) % 10));
      chk("dig_sel", 32'(dig_sel), 32'(sel));
   endtask

   initial begin
      logic [15:0] lv;
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 1, 16'h9999);
      chk("rst_count", 32'(count), 0);
      chk("rst_sel", 32'(dig_sel), 1);
      cyc(1, 0, 1, 0, 0, 16'h0099);
      cyc(1, 0, 0, 1, 1, 0);
      chk("carry", 32'(count), 32'h0100);
      cyc(1, 0, 0, 1, 0, 0);
      chk("borrow", 32'(count), 32'h0099);
      cyc(1, 0, 1, 0, 0, 16'h9999);
      cyc(1, 0, 0, 1, 1, 0);
      chk("wrap_up", 32'({wrap, count}), 32'h10000);
      cyc(1, 0, 0, 0, 1, 0);
      chk("wrap_clr", 32'(wrap), 0);
      cyc(1, 0, 0, 1, 0, 0);
      chk("wrap_dn", 32'({wrap, count}), 32'h19999);
      cyc(1, 0, 1, 0, 0, 16'h12A4);
      chk("load_fix", 32'(count), 32'h1204);
      cyc(1, 1, 1, 1, 1, 16'h5555);
      chk("prio", 32'(count), 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 16'h0042);
      for (int i = 0; i < 24; i++) cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         lv = 16'($urandom);
         case ($urandom_range(0, 3))
            0: lv = 16'h9999;
            1: lv = 16'h0000;
            default: ;
         endcase
         cyc($urandom_range(0, 63) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, lv);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n, errs);
      $finish;
   end
endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD decades; legal range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 1000: clock cycles each digit is displayed; legal minimum 1.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port clear  input  1: synchronous zeroing of the count.
REQ-006 SHALL have port load  input  1: load load_val into the count.
REQ-007 SHALL have port load_val  input  4*DIGITS: packed BCD value to load; digit 0 in bits [3:0].
REQ-008 SHALL have port en  input  1: count-step strobe; one step per cycle held high.
REQ-009 SHALL have port up  input  1: direction; 1 counts up, 0 counts down.
REQ-010 SHALL have port count  output  4*DIGITS: current packed BCD count.
REQ-011 SHALL have port wrap  output  1: one-cycle pulse on full-range wrap.
REQ-012 SHALL have port bcd  output  4: BCD nibble of the digit being scanned, feeding the downstream 7-segment decoder.
REQ-013 SHALL have port dig_sel  output  DIGITS: one-hot, active-high digit enable; bit i selects digit i.

Function
REQ-014 Priority per cycle SHALL be clear > load > en; lower-priority requests in the same cycle are ignored.
REQ-015 clear SHALL set count to all zeros on the next edge; wrap stays 0.
REQ-016 load SHALL set count to load_val on the next edge; any nibble >9 SHALL be stored as 0.
REQ-017 en with up=1 SHALL increment digit 0; a digit at 9 SHALL go to 0 and carry into the next digit in the same cycle.
REQ-018 en with up=0 SHALL decrement digit 0; a digit at 0 SHALL go to 9 and borrow from the next digit in the same cycle.
REQ-019 Up from all-9s SHALL give all-0s; down from all-0s SHALL give all-9s; each SHALL assert wrap for exactly the cycle in which count shows the wrapped value.
REQ-020 Count latency SHALL be one cycle: count reflects a clear/load/en on the edge that samples it.
REQ-021 A prescaler SHALL count 0..SCAN_DIV-1; on its terminal value the scan index SHALL advance 0,1,..,DIGITS-1,0 and the prescaler returns to 0.
REQ-022 SCAN_DIV=1 SHALL advance the scan index every cycle.
REQ-023 bcd SHALL equal digit[scan index] of the registered count; dig_sel SHALL have only bit [scan index] set. Both are decoded from registers only, with no input-to-output combinational path.
REQ-024 Count operations SHALL NOT disturb the prescaler or the scan index.

Reset
REQ-025 While rst_n is low at an edge: count=0, wrap=0, prescaler=0, scan index=0. Hence bcd=0 and dig_sel=one-hot bit 0.
REQ-026 Reset SHALL override clear, load and en. Reset mid-scan or mid-count SHALL restart the scan at digit 0 with a full SCAN_DIV dwell after release.

Configuration
REQ-027 With macro BCD_SCAN_LEADING_ZERO_BLANK_EN defined, dig_sel SHALL be forced to 0 while the scanned digit is a leading zero. A leading zero is a zero digit with all higher digits also zero. Digit 0 is never blanked. Scan timing is unchanged.
REQ-028 Without the macro, every digit SHALL be enabled during its scan slot.

Structure
REQ-029 Shared package bcd_disp_pkg SHALL hold DIGIT_W=4, BCD_MAX=4'd9 and typedef bcd_digit_t (4-bit), for use by this block and the 7-segment decoder.
REQ-030 One sub-module bcd_digit_cell SHALL implement a single decade, instantiated DIGITS times in a carry/borrow chain. Ports: clk, rst_n, clear, load, load_digit, step_in, up, digit, step_out.

Verification (DIGITS=4)
REQ-031 Hold rst_n low for 2 cycles -> count=16'h0000, wrap=0, bcd=0, dig_sel=4'b0001.
REQ-032 count=16'h0099, en=1 and up=1 for one cycle -> count=16'h0100, wrap=0. Then up=0, en one cycle -> 16'h0099.
REQ-033 count=16'h9999, up-step -> 16'h0000 with wrap=1 for one cycle. Then count=16'h0000, down-step -> 16'h9999 with wrap=1.
REQ-034 load=1 with load_val=16'h12A4 -> count=16'h1204. clear=1, load=1 and en=1 together -> count=16'h0000.
REQ-035 SCAN_DIV=3 with count=16'h0042 -> dig_sel is 0001 (bcd=2), then 0010 (bcd=4), 0100 (bcd=0), 1000 (bcd=0), each for 3 cycles, then repeats. With BCD_SCAN_LEADING_ZERO_BLANK_EN, the 0100 and 1000 slots read dig_sel=0000.
